sram_like_responder: RTL

Target end of the core's SRAM-like bus: accepts address-phase requests, performs reads/writes on an internal word-addressed memory and returns in-order data-phase responses. It is the bench/SoC-side model for the instruction and data ports: programmable latency, bounded outstanding depth and optional pseudo-random stall injection, so fetch/flush corner cases are exercised cycle-accurately.

---
 rtl/sram_like_responder_pkg.sv | 25 ++
 rtl/sram_like_responder_response_queue.sv | 86 ++++++++
 rtl/sram_like_responder.sv | 101 ++++++++++
 3 files changed

// File: rtl/sram_like_responder_pkg.sv
// Shared types, constants and the LFSR step used by the SRAM-like bus responder
// and its in-order response queue.
package sram_like_params;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } sram_size_t;

    localparam int         DELAY_W   = 8;
    localparam logic [7:0] LFSR_SEED = 8'h5a;

    typedef struct packed {
        logic               is_write;
        logic [31:0]        data;
        logic [DELAY_W-1:0] remaining_delay;
    } response_entry_t;

    // Fibonacci LFSR for x^8 + x^6 + x^5 + x^4 + 1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    endfunction

endpackage

// File: rtl/sram_like_responder_response_queue.sv
// In-order response FIFO; every stored entry counts its own delay down to zero
// regardless of its position, so a response is ready as soon as it reaches the head.
module sram_like_response_queue
    import sram_like_params::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push_i,
    input  response_entry_t push_entry_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output response_entry_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    response_entry_t  entry_q [DEPTH];
    response_entry_t  entry_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = entry_q[rd_ptr_q];

    always_comb begin
        entry_d  = entry_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].remaining_delay != '0) begin
                entry_d[i].remaining_delay = entry_q[i].remaining_delay - DELAY_W'(1);
            end else begin
                entry_d[i].remaining_delay = '0;
            end
        end
        // A push overwrites the countdown applied above; the freed slot is reused only next cycle.
        if (push_i) begin
            entry_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            entry_q  <= entry_d;
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like bus target: word-addressed backing store, bounded outstanding
// requests, in-order responses with programmable latency and optional LFSR stalls.
module sram_like_responder
    import sram_like_params::*;
#(
    parameter int MEMORY_WORDS = 4096,
    parameter int OUTSTANDING  = 2,
    parameter int READ_LATENCY = 1,
    parameter int RANDOM_DELAY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    output logic [31:0] read_data,
    output logic        address_ready,
    output logic        data_ready
);

    localparam int AW = $clog2(MEMORY_WORDS);

    logic [31:0]        mem_q [MEMORY_WORDS];
    logic [7:0]         lfsr_q, lfsr_d;
    logic [AW-1:0]      word_s;
    logic [DELAY_W-1:0] extra_s;
    logic               full_s, empty_s, pop_s;
    response_entry_t    push_entry_s, head_s;

    // Transfer size and byte offset never affect word selection; alignment is the master's concern.
    sram_size_t unused_size_s;
    logic       unused_addr_s;
    assign unused_size_s = sram_size_t'(size);
    assign unused_addr_s = ^{address[31:AW+2], address[1:0]};

    assign word_s        = address[AW+1:2];
    assign address_ready = request && !reset && !full_s;
    assign pop_s         = !reset && !empty_s && (head_s.remaining_delay == '0);
    assign data_ready    = pop_s;
    assign read_data     = (pop_s && !head_s.is_write) ? head_s.data : 32'h0;

    always_comb begin
        push_entry_s = '0;
        extra_s      = '0;
        lfsr_d       = lfsr_q;
        if (RANDOM_DELAY != 0) begin
            extra_s = {{(DELAY_W - 2){1'b0}}, lfsr_q[1:0]};
        end else begin
            extra_s = '0;
        end
        push_entry_s.is_write = write;
        // Reads capture the word as it stands before any write on the same edge.
        if (write) begin
            push_entry_s.data = 32'h0;
        end else begin
            push_entry_s.data = mem_q[word_s];
        end
        push_entry_s.remaining_delay = DELAY_W'(READ_LATENCY - 1) + extra_s;
        if (address_ready) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Backing store deliberately survives reset.
    always_ff @(posedge clock) begin
        if (address_ready && write) begin
            for (int i = 0; i < 4; i++) begin
                if (write_strobe[i]) begin
                    mem_q[word_s][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    sram_like_response_queue #(
        .DEPTH (OUTSTANDING)
    ) u_queue (
        .clock        (clock),
        .reset        (reset),
        .push_i       (address_ready),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .head_o       (head_s)
    );

endmodule
